// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard
// using request-to-send, bit clocking, odd parity, stop bit, device ACK and
// a transfer timeout. Lines are open-collector; *_oe = 1 pulls the line low.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_din_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FW = 10;
    localparam int unsigned BW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t          state;
    logic            clk_s1, clk_s2, clk_prev;
    logic            dat_s1, dat_s2;
    logic [FW-1:0]   frame;
    logic [BW-1:0]   bit_cnt;
    logic [IW-1:0]   inh_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            fall_c;
    logic            tmo_active_c;
    logic            timeout_c;

    assign fall_c       = clk_prev & ~clk_s2;
    assign tmo_active_c = (state == S_SEND) || (state == S_ACK) || (state == S_WAIT_IDLE);
    assign timeout_c    = tmo_active_c && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Two-flop synchronisers for both lines plus the clock edge register.
    // Reset to 1 (idle bus) so no false falling edge appears after reset.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_din_in;
            dat_s2   <= dat_s1;
        end
    end

    // Transfer FSM with registered outputs; timeout overrides any coincident fall.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            frame      <= '0;
            bit_cnt    <= '0;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (tmo_active_c) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (timeout_c) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                error      <= 1'b1;
                done       <= 1'b1;
                state      <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        // busy still high here means done pulsed last cycle
                        if (start && !busy) begin
                            frame      <= {1'b1, ~^din, din};
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            inh_cnt    <= '0;
                            ps2_clk_oe <= 1'b1;
                            state      <= S_INHIBIT;
                        end else begin
                            busy <= 1'b0;
                        end
                    end
                    S_INHIBIT: begin
                        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                            ps2_dat_oe <= 1'b1;
                            state      <= S_RTS;
                        end else begin
                            inh_cnt <= inh_cnt + IW'(1);
                        end
                    end
                    S_RTS: begin
                        ps2_clk_oe <= 1'b0;
                        tmo_cnt    <= '0;
                        bit_cnt    <= '0;
                        state      <= S_SEND;
                    end
                    S_SEND: begin
                        if (fall_c) begin
                            ps2_dat_oe <= ~frame[0];
                            frame      <= {1'b0, frame[FW-1:1]};
                            bit_cnt    <= bit_cnt + BW'(1);
                            if (bit_cnt == BW'(FW - 1)) begin
                                state <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (fall_c) begin
                            error <= dat_s2;
                            state <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (clk_s2 && dat_s2) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte from the FPGA to the attached keyboard (set LEDs 0xED, reset 0xFF, typematic 0xF3, …) over the shared open-collector PS/2 clock/data lines. It handles the full host-to-device protocol: request-to-send, bit clocking, odd parity, stop bit, device ACK, and timeout. It sits beside `ps2keyboard` in the Apple-1 core. `busy` is used at top level to mask the receiver while a host transfer owns the lines.

## Interface
- INHIBIT_CYCLES, 2500: clk25 cycles the clock line is held low for request-to-send (100 µs at 25 MHz).
- TIMEOUT_CYCLES, 375000: maximum clk25 cycles from clock release to transfer end (15 ms). Counter width is derived from this value.

- clk25  in  1  master clock, 25 MHz
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to send `din`; honoured only in IDLE
- din  in  8  command byte, captured on accepted `start`
- busy  out  1  high from accepted `start` until the cycle after `done`
- done  out  1  one-cycle pulse at end of transfer (success or failure)
- error  out  1  valid with `done`; held until the next accepted `start`; 1 = NACK or timeout
- ps2_clk_in  in  1  raw PS/2 clock line (asynchronous)
- ps2_din_in  in  1  raw PS/2 data line (asynchronous)
- ps2_clk_oe  out  1  1 = pull clock line low, 0 = release
- ps2_dat_oe  out  1  1 = pull data line low, 0 = release

## Operation
- **Synchronisers:** `ps2_clk_in` and `ps2_din_in` each pass through two flops. A registered copy of the synchronised clock forms `fall` (previous = 1, current = 0).
- **Frame:** shift register `{stop=1, parity=~^din, din[7:0]}`, sent LSB first after the start bit (0). `ps2_dat_oe = ~current_bit`.
- **State IDLE:** all outputs 0 except a held `error`.
  - On `start`: latch the frame, clear `error`, set `busy`.
  - Go to INHIBIT.
- **State INHIBIT:** `ps2_clk_oe = 1` for exactly INHIBIT_CYCLES cycles. Then go to RTS.
- **State RTS (1 cycle):** `ps2_clk_oe = 1` and `ps2_dat_oe = 1` (start bit).
  - Go to SEND.
  - The timeout counter clears to 0.
- **State SEND:** `ps2_clk_oe = 0`. On each `fall`, advance one bit:
  - falls 1–8: data bits 0–7
  - fall 9: parity
  - fall 10: stop, so `ps2_dat_oe = 0`
  - Go to ACK after fall 10.
- **State ACK:** on the next `fall`, sample the synchronised data line.
  - 0 = ACK, so `error = 0`.
  - 1 = NACK, so `error = 1`.
  - Go to WAIT_IDLE.
- **State WAIT_IDLE:** wait until both synchronised lines are 1. Then pulse `done` and go to IDLE.
- **Timeout:** in SEND, ACK and WAIT_IDLE the counter increments every cycle. When it reaches TIMEOUT_CYCLES-1:
  - Release both lines.
  - Set `error = 1` and pulse `done`.
  - Go to IDLE.
  - Timeout takes priority over a coincident `fall`.
- **Edge-case rules:**
  - `start` while `busy` is ignored; the latched byte is not altered.
  - `fall` seen in IDLE, INHIBIT or RTS is ignored.
- **Reset (asynchronous, any state including mid-frame):**
  - State = IDLE; `busy`, `done`, `error`, `ps2_clk_oe`, `ps2_dat_oe` = 0; counters cleared.
  - The lines are released immediately.

## Timing
- `start` high at edge N: `busy = 1` and `ps2_clk_oe = 1` from edge N+1.
- `ps2_clk_oe` is high for INHIBIT_CYCLES + 1 cycles in total (INHIBIT plus RTS).
- `ps2_dat_oe` rises in the last of those cycles.
- Data change latency: `ps2_dat_oe` updates 3 clk25 edges after the raw `ps2_clk_in` falls (2 sync flops + edge register, 120 ns). This is well inside the device's ≥30 µs clock-low phase.
- `done` is asserted 1 cycle after both synchronised lines are seen high in WAIT_IDLE.
- `busy` drops on the cycle after `done`.
- A new `start` is accepted in the cycle after `busy` falls.
- Timeout fires exactly TIMEOUT_CYCLES cycles after entry to SEND if the frame is unfinished.

## Test plan
- **Send 0xED with a keyboard model ACKing** (model clocks 40 µs period, samples data on rising edge):
  - Model receives bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - `done` pulses with `error = 0`; `busy` low the next cycle.
- **Send 0x01, 0x00 and 0xFF:**
  - Parity seen 0, 1, 1 respectively.
  - 0x00 shows 8 low data bits, then the line released for stop.
- **Model drives ACK high (NACK) on clock 11:** `done` pulses with `error = 1`; both OE outputs 0.
- **No device clocks after RTS:**
  - Exactly TIMEOUT_CYCLES cycles after RTS, `done` pulses with `error = 1`; lines released.
  - Next `start` accepted and `error` cleared.
- **Busy guard:** `start` with 0x55 pulsed during INHIBIT of a 0xF3 transfer → the model receives 0xF3 only, and exactly one `done`.
- **Mid-frame reset:** assert `rst` after data bit 4.
  - `ps2_clk_oe = ps2_dat_oe = busy = 0` without waiting for a clock edge.
  - After release, `start` with 0xFF completes normally.
